// File: rtl/rgb_stream_packer_pkg.sv
// rgb_pack_pkg
// Shared types and constants for the RGB stream packer family:
//   mode_e  - per-packet packing mode (PAD / DENSE)
//   state_e - packer control state (RUN / FLUSH)
//   KEEP_*  - per-lane keep masks for full and partial output words
package rgb_pack_pkg;

  typedef enum logic {
    MODE_PAD   = 1'b0,
    MODE_DENSE = 1'b1
  } mode_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  localparam logic [3:0] KEEP_FULL = 4'b1111;
  localparam logic [3:0] KEEP_3    = 4'b0111;
  localparam logic [3:0] KEEP_2    = 4'b0011;
  localparam logic [3:0] KEEP_1    = 4'b0001;

endpackage

// File: rtl/rgb_stream_packer_outreg.sv
// rgb_pack_outreg
// Single-entry registered output stage for valid/ready streams.
// Ports:
//   i_clk, i_rstn          clock, asynchronous active-low reset
//   i_load                 load i_data/i_keep/i_last (honoured only when o_free)
//   i_data, i_keep, i_last word presented for loading
//   i_ready                downstream ready
//   o_valid, o_data,
//   o_keep, o_last         registered output word
//   o_free                 register can accept a new word this cycle
module rgb_pack_outreg #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic [3:0]   i_keep,
  input  logic         i_last,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic [3:0]   o_keep,
  output logic         o_last,
  output logic         o_free
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic [3:0]   r_keep;
  logic         r_last;

  // Free when empty or when the held word leaves this cycle, so a new word
  // can replace a departing one without a bubble.
  assign o_free = !r_valid || i_ready;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (i_load && o_free) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_last  = r_last;

endmodule

// File: rtl/rgb_stream_packer.sv
// rgb_stream_packer
// Packs a stream of 3*CW-bit RGB pixels into 4*CW-bit words, either padding
// each pixel with ALPHA (PAD) or densely packing 4 pixels into 3 words (DENSE).
// Ports:
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   mode_i                 0=PAD, 1=DENSE, sampled on the first beat of a packet
//   in_valid_i/in_ready_o  input pixel handshake
//   in_data_i, in_last_i   pixel {R,G,B} (B in low lane), end of packet
//   out_valid_o/out_ready_i output word handshake
//   out_data_o, out_keep_o, out_last_o  packed word, lane mask, end of packet
module rgb_stream_packer
  import rgb_pack_pkg::*;
#(
  parameter int            CW    = 8,
  parameter logic [CW-1:0] ALPHA = {CW{1'b1}}
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          mode_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [3*CW-1:0] in_data_i,
  input  logic          in_last_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [4*CW-1:0] out_data_o,
  output logic [3:0]    out_keep_o,
  output logic          out_last_o
);

  state_e           r_state, w_state_next;
  mode_e            r_mode, w_mode_next, w_mode;
  logic             r_sop, w_sop_next;
  logic [1:0]       r_phase, w_phase_next;
  // Residual components, always right-aligned with unused upper lanes zero so
  // it can be emitted directly as a partial word.
  logic [3*CW-1:0]  r_res, w_res_next;

  logic             w_free;
  logic             w_acc;
  logic             w_load;
  logic [4*CW-1:0]  w_word;
  logic [3:0]       w_keep;
  logic             w_last;
  logic [CW-1:0]    w_c0, w_c1, w_c2;

  assign w_c0 = in_data_i[0*CW +: CW];
  assign w_c1 = in_data_i[1*CW +: CW];
  assign w_c2 = in_data_i[2*CW +: CW];

  assign in_ready_o = (r_state == ST_RUN) && w_free;
  assign w_acc      = in_valid_i && in_ready_o;
  // First beat of a packet uses the live mode input, later beats the latched one.
  assign w_mode     = r_sop ? mode_e'(mode_i) : r_mode;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_RUN;
      r_mode  <= MODE_PAD;
      r_sop   <= 1'b1;
      r_phase <= 2'd0;
      r_res   <= '0;
    end else begin
      r_state <= w_state_next;
      r_mode  <= w_mode_next;
      r_sop   <= w_sop_next;
      r_phase <= w_phase_next;
      r_res   <= w_res_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mode_next  = r_mode;
    w_sop_next   = r_sop;
    w_phase_next = r_phase;
    w_res_next   = r_res;
    w_load       = 1'b0;
    w_word       = '0;
    w_keep       = '0;
    w_last       = 1'b0;

    if (r_state == ST_FLUSH) begin
      // Phase 2 here means 2 components left over, phase 3 means 1.
      if (w_free) begin
        w_load       = 1'b1;
        w_word       = {{CW{1'b0}}, r_res};
        w_keep       = (r_phase == 2'd2) ? KEEP_2 : KEEP_1;
        w_last       = 1'b1;
        w_state_next = ST_RUN;
        w_phase_next = 2'd0;
        w_res_next   = '0;
      end
    end else if (w_acc) begin
      w_sop_next  = in_last_i;
      w_mode_next = w_mode;
      if (w_mode == MODE_PAD) begin
        w_load = 1'b1;
        w_word = {ALPHA, in_data_i};
        w_keep = KEEP_FULL;
        w_last = in_last_i;
      end else begin
        w_phase_next = r_phase + 2'd1;
        case (r_phase)
          2'd0: begin
            if (in_last_i) begin
              w_load       = 1'b1;
              w_word       = {{CW{1'b0}}, in_data_i};
              w_keep       = KEEP_3;
              w_last       = 1'b1;
              w_phase_next = 2'd0;
              w_res_next   = '0;
            end else begin
              w_res_next = in_data_i;
            end
          end
          2'd1: begin
            w_load     = 1'b1;
            w_word     = {w_c0, r_res};
            w_keep     = KEEP_FULL;
            w_res_next = {{CW{1'b0}}, w_c2, w_c1};
            if (in_last_i) w_state_next = ST_FLUSH;
          end
          2'd2: begin
            w_load     = 1'b1;
            w_word     = {w_c1, w_c0, r_res[2*CW-1:0]};
            w_keep     = KEEP_FULL;
            w_res_next = {{(2*CW){1'b0}}, w_c2};
            if (in_last_i) w_state_next = ST_FLUSH;
          end
          default: begin
            w_load       = 1'b1;
            w_word       = {w_c2, w_c1, w_c0, r_res[CW-1:0]};
            w_keep       = KEEP_FULL;
            w_last       = in_last_i;
            w_res_next   = '0;
            w_phase_next = 2'd0;
          end
        endcase
      end
    end
  end

  rgb_pack_outreg #(.W(4*CW)) u_outreg (
    .i_clk   (clk_i),
    .i_rstn  (rstn_i),
    .i_load  (w_load),
    .i_data  (w_word),
    .i_keep  (w_keep),
    .i_last  (w_last),
    .i_ready (out_ready_i),
    .o_valid (out_valid_o),
    .o_data  (out_data_o),
    .o_keep  (out_keep_o),
    .o_last  (out_last_o),
    .o_free  (w_free)
  );

endmodule

// File: doc/rgb_stream_packer.md
# rgb_stream_packer

Streaming RGB-to-32-bit word packer: the parametrised, handshaked successor to the fixed 24→32 alpha-pad conversion. It accepts one RGB pixel per beat and, per packet, either pads each pixel with a constant alpha component (PAD mode) or densely packs 4 pixels into 3 output words (DENSE mode), flushing a partial word at end of packet. It sits between the video timing/pixel source and the frame-buffer write DMA (AXI-Stream-style valid/ready on both sides).

## Interface
- CW, 8, component width in bits; pixel = 3*CW, output word = 4*CW
- ALPHA, {CW{1'b1}}, alpha component inserted in PAD mode
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous, active-low reset
- mode_i  in  1  0 = PAD, 1 = DENSE; latched at first beat of each packet
- in_valid_i  in  1  input pixel valid
- in_ready_o  out  1  input pixel accepted when valid&ready
- in_data_i  in  3*CW  pixel {R,G,B}; component 0 = B in [CW-1:0]
- in_last_i  in  1  last pixel of packet (line)
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  4*CW  packed word; component lane k = bits [k*CW +: CW]
- out_keep_o  out  4  per-lane valid mask
- out_last_o  out  1  last word of packet

## Operation
- One clock, one asynchronous active-low reset; all state resets asynchronously.
- Component stream is LSB-first: pixel components 0,1,2 in order, pixels in arrival order.
- PAD: each accepted pixel → one word {ALPHA, pixel}, keep=4'b1111, out_last = in_last.
- DENSE: residual buffer holds 0–3 components; phase counter 0..3 (pixels into current 4-pixel group).
  - phase0: store 3 comps, no output. phase1: emit {p1[CW-1:0], p0}, keep 2 comps. phase2: emit {p2[2CW-1:0], res}, keep 1. phase3: emit {p3, res}, residual empty, phase→0.
  - in_last with zero residual after emit: that word carries out_last, phase→0.
  - in_last at phase0: emit residual as partial word immediately (keep 4'b0111, last=1).
  - in_last at phase1/2 (full word plus residual): emit full word (last=0), enter FLUSH, then emit partial word (keep 0011 for 2 comps, 0001 for 1 comp, last=1).
- Unused lanes in partial words drive zero.
- States: RUN (accept input), FLUSH (in_ready_o=0, present partial word once output register is free, then → RUN, phase→0).
- mode latched on first accepted beat after reset or after a beat with in_last; mode_i changes mid-packet are ignored.

## Timing
- Reset values: out_valid_o=0, out_data_o=0, out_keep_o=0, out_last_o=0, phase=0, residual empty, state RUN, mode_r=PAD; in_ready_o=1 one cycle after reset deasserts.
- in_ready_o = (state==RUN) && (!out_valid_o || out_ready_i) — combinational, no dependency on in_valid_i.
- Latency: output word registered, valid the cycle after the producing input handshake.
- Throughput: PAD 1 word/cycle; DENSE 3 words per 4 pixels; FLUSH costs exactly one input-stall cycle when out_ready_i=1.
- out_data/keep/last hold stable while out_valid_o=1 and out_ready_i=0.
- Simultaneous out handshake and new input in the same cycle: new word loads, no bubble.
- Reset mid-packet discards residual and any pending word; no partial word emitted.

## Structure
- Package rgb_pack_pkg: mode enum (PAD/DENSE), state enum (RUN/FLUSH), keep constants KEEP_FULL/KEEP_3/KEEP_2/KEEP_1.
- Sub-module rgb_pack_outreg: single-entry output register (data, keep, last, valid, load/ready logic), reused by future stream converters.

## Test plan
- PAD, CW=8, pixel 0x112233 last=1 → word 0xFF112233, keep 1111, last 1, one cycle latency.
- DENSE, pixels 0x112233,0x445566,0x778899,0xAABBCC (last on 4th) → 0x66112233, 0x88994455, 0xAABBCC77 (last=1), keep 1111 each.
- DENSE, 0x112233,0x445566 (last on 2nd) → 0x66112233 last0, then 0x00004455 keep 0011 last1; in_ready_o low one cycle.
- DENSE, single pixel 0x112233 last=1 → 0x00112233 keep 0111 last1, no FLUSH stall.
- Backpressure: out_ready_i random 50% over 1000 random-length packets, both modes → output matches reference model, no loss/duplication, data stable while stalled.
- Assert rstn_i low during phase2 of a DENSE packet → all outputs 0 immediately; next packet packs from phase0 with no residual leakage.
